// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 microsequencer: control-word fields,
// MIR slice bit positions, B-bus select codes, ALU bits and FSM states.
package mic1_pkg;

  localparam int MPC_WIDTH = 9;

  localparam int CW_NEXT_LSB = 27;
  localparam int CW_JMPC     = 26;
  localparam int CW_JAMN     = 25;
  localparam int CW_JAMZ     = 24;
  localparam int CW_ALU_LSB  = 16;
  localparam int CW_DP_LSB   = 0;

  localparam int MIR_C_H     = 15;
  localparam int MIR_C_OPC   = 14;
  localparam int MIR_C_TOS   = 13;
  localparam int MIR_C_CPP   = 12;
  localparam int MIR_C_LV    = 11;
  localparam int MIR_C_SP    = 10;
  localparam int MIR_C_PC    = 9;
  localparam int MIR_C_MDR   = 8;
  localparam int MIR_C_MAR   = 7;
  localparam int MIR_WRITE   = 6;
  localparam int MIR_READ    = 5;
  localparam int MIR_FETCH   = 4;
  localparam int MIR_B_LSB   = 0;

  typedef enum logic [3:0] {
    B_MDR  = 4'd0,
    B_PC   = 4'd1,
    B_MBR  = 4'd2,
    B_MBRU = 4'd3,
    B_SP   = 4'd4,
    B_LV   = 4'd5,
    B_CPP  = 4'd6,
    B_TOS  = 4'd7,
    B_OPC  = 4'd8
  } b_sel_e;

  localparam int ALU_SLL8 = 7;
  localparam int ALU_SRA1 = 6;
  localparam int ALU_F0   = 5;
  localparam int ALU_F1   = 4;
  localparam int ALU_ENA  = 3;
  localparam int ALU_ENB  = 2;
  localparam int ALU_INVA = 1;
  localparam int ALU_INC  = 0;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_EXEC    = 2'd1,
    S_MEMWAIT = 2'd2
  } state_e;

endpackage

// File: rtl/mic1_microsequencer_if.sv
// Control-store and memory handshake bundle between the sequencer (master)
// and the ROM / memory side (slave).
interface mic1_microsequencer_if #(
  parameter int CS_WIDTH  = 36,
  parameter int MPC_WIDTH = 9
);
  logic [MPC_WIDTH-1:0] cs_addr;
  logic [CS_WIDTH-1:0]  cs_data;
  logic                 mem_ready;
  logic                 ram_rd;
  logic                 ram_wr;
  logic                 rom_rd;

  modport master (
    output cs_addr, ram_rd, ram_wr, rom_rd,
    input  cs_data, mem_ready
  );

  modport slave (
    input  cs_addr, ram_rd, ram_wr, rom_rd,
    output cs_data, mem_ready
  );
endinterface

// File: rtl/mic1_next_addr.sv
// Next micro-PC: NEXT_ADDRESS with MBR OR-ed into the low byte (JMPC) and
// the ALU flags OR-ed into bit 8 (JAMZ/JAMN).
module mic1_next_addr
  import mic1_pkg::*;
(
  input  logic [MPC_WIDTH-1:0] next_addr,
  input  logic                 jmpc,
  input  logic                 jamn,
  input  logic                 jamz,
  input  logic                 alu_n,
  input  logic                 alu_z,
  input  logic [7:0]           mbr,
  output logic [MPC_WIDTH-1:0] next_mpc
);
  assign next_mpc = {next_addr[8] | (jamz & alu_z) | (jamn & alu_n),
                     next_addr[7:0] | (jmpc ? mbr : 8'h00)};
endmodule

// File: rtl/mic1_microsequencer.sv
// MIC-1 microprogram controller: LOAD -> EXEC -> (MEMWAIT) loop over the control store.
// Optional memory wait timeout enabled by defining MIC1_MEM_TIMEOUT_EN.
module mic1_microsequencer
  import mic1_pkg::*;
#(
  parameter int CS_WIDTH       = 36,
  parameter int MPC_WIDTH      = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mic1_microsequencer_if.master mem,
  input  logic                 alu_n,
  input  logic                 alu_z,
  input  logic [7:0]           mbr,
  output logic [15:0]          MIR,
  output logic [7:0]           alu_ctrl,
  output logic [MPC_WIDTH-1:0] mpc,
  output logic                 n_flag,
  output logic                 z_flag,
  output logic                 timeout_err
);
  state_e               state_q, state_d;
  logic [MPC_WIDTH-1:0] mpc_q, mpc_d, nxt_q, nxt_d, next_mpc;
  logic [CS_WIDTH-1:0]  mir_q, mir_d;
  logic                 n_q, n_d, z_q, z_d;
  logic                 rd_w, wr_w, fe_w, rd_eff;

  assign wr_w   = mir_q[MIR_WRITE];
  assign rd_w   = mir_q[MIR_READ];
  assign fe_w   = mir_q[MIR_FETCH];
  assign rd_eff = rd_w & ~wr_w;

  mic1_next_addr u_next_addr (
    .next_addr (mir_q[CW_NEXT_LSB +: MPC_WIDTH]),
    .jmpc      (mir_q[CW_JMPC]),
    .jamn      (mir_q[CW_JAMN]),
    .jamz      (mir_q[CW_JAMZ]),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .mbr       (mbr),
    .next_mpc  (next_mpc)
  );

`ifdef MIC1_MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tmo;
  assign tmo         = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;
`else
  // Without the timeout feature the error output is a constant 0.
  localparam logic TMO_NONE = (TIMEOUT_CYCLES < 0);
  assign timeout_err = TMO_NONE;
`endif

  always_comb begin
    state_d    = state_q;
    mpc_d      = mpc_q;
    nxt_d      = nxt_q;
    mir_d      = mir_q;
    n_d        = n_q;
    z_d        = z_q;
    MIR        = 16'h0000;
    alu_ctrl   = 8'h00;
    mem.ram_rd = 1'b0;
    mem.ram_wr = 1'b0;
    mem.rom_rd = 1'b0;
`ifdef MIC1_MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_LOAD: begin
        mir_d   = mem.cs_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        MIR            = mir_q[CW_DP_LSB +: 16];
        MIR[MIR_READ]  = 1'b0;
        MIR[MIR_FETCH] = 1'b0;
        alu_ctrl       = mir_q[CW_ALU_LSB +: 8];
        n_d            = alu_n;
        z_d            = alu_z;
        nxt_d          = next_mpc;
        if (rd_w | wr_w | fe_w) begin
          state_d = S_MEMWAIT;
`ifdef MIC1_MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          mpc_d   = next_mpc;
          state_d = S_LOAD;
        end
      end
      S_MEMWAIT: begin
        mem.ram_wr     = wr_w;
        mem.ram_rd     = rd_eff;
        mem.rom_rd     = fe_w;
        MIR[MIR_READ]  = rd_eff & mem.mem_ready;
        MIR[MIR_FETCH] = fe_w & mem.mem_ready;
        if (mem.mem_ready) begin
          mpc_d   = nxt_q;
          state_d = S_LOAD;
        end
`ifdef MIC1_MEM_TIMEOUT_EN
        else if (tmo) begin
          err_d   = 1'b1;
          mpc_d   = nxt_q;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_LOAD;
      mpc_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
`ifdef MIC1_MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mpc_q   <= mpc_d;
      n_q     <= n_d;
      z_q     <= z_d;
`ifdef MIC1_MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // MIR word and pending next-MPC are only consumed after LOAD/EXEC writes them.
  always_ff @(posedge clock) begin
    mir_q <= mir_d;
    nxt_q <= nxt_d;
  end

  assign mem.cs_addr = mpc_q;
  assign mpc         = mpc_q;
  assign n_flag      = n_q;
  assign z_flag      = z_q;
endmodule

// File: tb/tb_mic1_microsequencer.sv
// Self-checking bench for mic1_microsequencer: transaction model expands each
// microinstruction into expected per-cycle outputs, compared every negedge.
module tb_mic1_microsequencer;
  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_n, alu_z;
  logic [7:0]  mbr;
  logic [15:0] mir_o;
  logic [7:0]  alu_o;
  logic [8:0]  mpc_o;
  logic        n_o, z_o, err_o;
  logic [35:0] rom [512];

  mic1_microsequencer_if #(.CS_WIDTH(36), .MPC_WIDTH(9)) bus ();

  mic1_microsequencer #(.CS_WIDTH(36), .MPC_WIDTH(9), .TIMEOUT_CYCLES(TMO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mem         (bus),
    .alu_n       (alu_n),
    .alu_z       (alu_z),
    .mbr         (mbr),
    .MIR         (mir_o),
    .alu_ctrl    (alu_o),
    .mpc         (mpc_o),
    .n_flag      (n_o),
    .z_flag      (z_o),
    .timeout_err (err_o)
  );

  assign bus.cs_data = rom[bus.cs_addr];

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [8:0]  addr;
    logic [15:0] mir;
    logic [7:0]  alu;
    logic        rd, wr, fe;
    logic [8:0]  mpc;
    logic        n, z, err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_cycles = 0;
  int   uid = 0;

  logic [8:0] mpc_m;
  logic       n_m, z_m, err_m;

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (uinstr %0d) got %h expected %h at %0t", name, id, got, want, $time);
    end
  endtask

  always @(negedge clock) begin
    if (bus.ram_rd === 1'b1) rd_cycles++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cs_addr",     e.id, 32'(bus.cs_addr), 32'(e.addr));
      chk("MIR",         e.id, 32'(mir_o),       32'(e.mir));
      chk("alu_ctrl",    e.id, 32'(alu_o),       32'(e.alu));
      chk("ram_rd",      e.id, 32'(bus.ram_rd),  32'(e.rd));
      chk("ram_wr",      e.id, 32'(bus.ram_wr),  32'(e.wr));
      chk("rom_rd",      e.id, 32'(bus.rom_rd),  32'(e.fe));
      chk("mpc",         e.id, 32'(mpc_o),       32'(e.mpc));
      chk("n_flag",      e.id, 32'(n_o),         32'(e.n));
      chk("z_flag",      e.id, 32'(z_o),         32'(e.z));
      chk("timeout_err", e.id, 32'(err_o),       32'(e.err));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] m, input logic [7:0] a, input logic rd, input logic wr, input logic fe);
    exp_t e;
    e.id = uid; e.addr = mpc_m; e.mir = m; e.alu = a;
    e.rd = rd; e.wr = wr; e.fe = fe;
    e.mpc = mpc_m; e.n = n_m; e.z = z_m; e.err = err_m;
    exp_q.push_back(e);
  endtask

  function automatic logic [35:0] mk(input int nxt, input bit jmpc, input bit jamn, input bit jamz,
                                     input int alu, input int dp);
    return (36'(nxt) << 27) | (36'(jmpc) << 26) | (36'(jamn) << 25) | (36'(jamz) << 24) |
           (36'(alu & 255) << 16) | 36'(dp & 16'hFFFF);
  endfunction

  // Runs one microinstruction starting in its LOAD cycle; k = cycles mem_ready stays low.
  task automatic run_ui(input logic [35:0] w, input logic n, input logic z, input logic [7:0] b, input int k);
    int  nxt, low, hi, waits;
    bit  rd, wr, fe, timed, rdy;
    logic [15:0] dp;
    uid++;
    dp = w[15:0];
    rd = dp[5]; wr = dp[6]; fe = dp[4];
    rom[mpc_m] = w;
    alu_n = n; alu_z = z; mbr = b; bus.mem_ready = 1'b0;
    push(16'h0000, 8'h00, 0, 0, 0);
    step();
    push(dp & ~16'h0030, w[23:16], 0, 0, 0);
    nxt = int'(w[35:27]);
    low = (nxt % 256) | (w[26] ? int'(b) : 0);
    hi  = (nxt / 256) | ((w[24] && z) ? 1 : 0) | ((w[25] && n) ? 1 : 0);
    n_m = n; z_m = z;
    step();
    if (rd || wr || fe) begin
      waits = k + 1;
      timed = 0;
`ifdef MIC1_MEM_TIMEOUT_EN
      if (k >= TMO) begin waits = TMO; timed = 1; end
`endif
      for (int j = 0; j < waits; j++) begin
        rdy = !timed && (j == k);
        bus.mem_ready = rdy;
        push({10'b0, rd && !wr && rdy, fe && rdy, 4'b0}, 8'h00, rd && !wr, wr, fe);
        step();
      end
      bus.mem_ready = 1'b0;
      if (timed) err_m = 1'b1;
    end
    mpc_m = 9'(hi * 256 + low);
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 512; i++) rom[i] = 36'h0;
    reset_n = 1'b0; alu_n = 0; alu_z = 0; mbr = 8'h00; bus.mem_ready = 1'b0;
    mpc_m = 9'h000; n_m = 0; z_m = 0; err_m = 0;
    step();
    step();
    chk("rst_mpc", 0, 32'(mpc_o), 32'h0);
    chk("rst_MIR", 0, 32'(mir_o), 32'h0);
    chk("rst_alu", 0, 32'(alu_o), 32'h0);
    chk("rst_strobes", 0, {29'b0, bus.ram_rd, bus.ram_wr, bus.rom_rd}, 32'h0);
    chk("rst_flags", 0, {29'b0, n_o, z_o, err_o}, 32'h0);
    chk("rst_cs_addr", 0, 32'(bus.cs_addr), 32'h0);
    reset_n = 1'b1;

    // Plain datapath word, then JAMZ/JAMN and JMPC address formation.
    run_ui(mk(9'h005, 0, 0, 0, 8'h3C, 16'h8001), 0, 0, 8'h00, 0);
    chk("pin_mpc_005", uid, 32'(mpc_o), 32'h005);
    run_ui(mk(9'h010, 0, 0, 1, 8'h00, 16'h0000), 0, 1, 8'h00, 0);
    chk("pin_jamz1", uid, 32'(mpc_o), 32'h110);
    run_ui(mk(9'h010, 0, 0, 1, 8'h00, 16'h0000), 1, 0, 8'h00, 0);
    chk("pin_jamz0", uid, 32'(mpc_o), 32'h010);
    run_ui(mk(9'h020, 0, 1, 0, 8'h81, 16'h4002), 1, 0, 8'h00, 0);
    chk("pin_jamn1", uid, 32'(mpc_o), 32'h120);
    run_ui(mk(9'h030, 0, 1, 0, 8'h00, 16'h0000), 0, 1, 8'h00, 0);
    chk("pin_jamn0", uid, 32'(mpc_o), 32'h030);
    run_ui(mk(9'h000, 1, 0, 0, 8'h00, 16'h0000), 0, 0, 8'h60, 0);
    chk("pin_jmpc_lo", uid, 32'(mpc_o), 32'h060);
    run_ui(mk(9'h100, 1, 0, 0, 8'h00, 16'h0000), 0, 0, 8'h60, 0);
    chk("pin_jmpc_hi", uid, 32'(mpc_o), 32'h160);

    // Memory accesses: READ with 3 wait cycles, FETCH, WRITE+READ, READ+FETCH.
    r0 = rd_cycles;
    run_ui(mk(9'h070, 0, 0, 0, 8'h14, 16'h8020), 0, 0, 8'h00, 3);
    chk("rd_len", uid, 32'(rd_cycles - r0), 32'd4);
    chk("pin_after_read", uid, 32'(mpc_o), 32'h070);
    run_ui(mk(9'h080, 0, 0, 0, 8'h35, 16'h0211), 0, 0, 8'h00, 2);
    run_ui(mk(9'h090, 0, 0, 0, 8'h00, 16'h0060), 0, 0, 8'h00, 0);
    run_ui(mk(9'h0A0, 1, 0, 0, 8'h00, 16'h0030), 0, 0, 8'h00, 1);
    chk("pin_after_rf", uid, 32'(mpc_o), 32'h0A0);

    // Reset while a READ is outstanding.
    rom[mpc_m] = mk(9'h0B0, 0, 0, 0, 8'h00, 16'h0020);
    alu_n = 1; alu_z = 1; bus.mem_ready = 1'b0;
    step();
    step();
    chk("pre_rst_rd", 99, 32'(bus.ram_rd), 32'h1);
    reset_n = 1'b0;
    step();
    chk("mid_rst_rd", 99, 32'(bus.ram_rd), 32'h0);
    chk("mid_rst_MIR", 99, 32'(mir_o), 32'h0);
    chk("mid_rst_mpc", 99, 32'(mpc_o), 32'h0);
    chk("mid_rst_flags", 99, {30'b0, n_o, z_o}, 32'h0);
    step();
    reset_n = 1'b1;
    mpc_m = 9'h000; n_m = 0; z_m = 0; err_m = 0;
    rom[0] = mk(9'h005, 0, 0, 0, 8'h3C, 16'h8001);
    run_ui(mk(9'h005, 0, 0, 0, 8'h3C, 16'h8001), 0, 0, 8'h00, 0);
    chk("pin_post_rst", uid, 32'(mpc_o), 32'h005);

`ifdef MIC1_MEM_TIMEOUT_EN
    run_ui(mk(9'h0C0, 0, 0, 0, 8'h00, 16'h0020), 0, 0, 8'h00, 10);
    chk("tmo_mpc", uid, 32'(mpc_o), 32'h0C0);
    chk("tmo_err", uid, 32'(err_o), 32'h1);
    run_ui(mk(9'h0D0, 0, 0, 0, 8'h00, 16'h0000), 0, 0, 8'h00, 0);
    chk("tmo_sticky", uid, 32'(err_o), 32'h1);
`endif

    step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
